// File: rtl/wb_queue_if.sv
// Bundle for the write-back queue: producer handshake, register-file write
// port, operand-forwarding lookups and occupancy.
interface wb_queue_if #(
   parameter int CW = 3
) ();
   logic          in_valid;
   logic [4:0]    in_reg;
   logic [31:0]   in_data;
   logic          in_ready;
   logic          wb_stall;
   logic          ctrl_writeEnable;
   logic [4:0]    ctrl_writeReg;
   logic [31:0]   data_writeReg;
   logic [4:0]    ctrl_readRegA;
   logic [4:0]    ctrl_readRegB;
   logic          fwdA_hit;
   logic          fwdB_hit;
   logic [31:0]   fwdA_data;
   logic [31:0]   fwdB_data;
   logic [CW-1:0] count;

   modport slave (
      input  in_valid, in_reg, in_data, wb_stall, ctrl_readRegA, ctrl_readRegB,
      output in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
             fwdA_hit, fwdB_hit, fwdA_data, fwdB_data, count
   );

   modport master (
      output in_valid, in_reg, in_data, wb_stall, ctrl_readRegA, ctrl_readRegB,
      input  in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
             fwdA_hit, fwdB_hit, fwdA_data, fwdB_data, count
   );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue: circular FIFO of pending register writes that drains into
// the register file and forwards the youngest pending value to read ports.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic       clock,
   input logic       ctrl_reset,
   wb_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          in_ready;
   logic          enq;
   logic          deq;
   logic [PW-1:0] idx;
   logic          hit_a, hit_b;
   logic [31:0]   data_a, data_b;

   // in_ready looks only at registered occupancy, never at this cycle's drain.
   assign in_ready = (count_q < CW'(DEPTH));

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      enq     = bus.in_valid && in_ready && (bus.in_reg != 5'd0);
      deq     = (count_q != '0) && !bus.wb_stall;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (deq) head_d = head_q + PW'(1);
      if (enq) tail_d = tail_q + PW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
   end

   // Scan oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      idx    = head_q;
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      data_a = '0;
      data_b = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if (CW'(k) < count_q) begin
            if ((bus.ctrl_readRegA != 5'd0) && (mem_q[idx].rd == bus.ctrl_readRegA)) begin
               hit_a  = 1'b1;
               data_a = mem_q[idx].data;
            end
            if ((bus.ctrl_readRegB != 5'd0) && (mem_q[idx].rd == bus.ctrl_readRegB)) begin
               hit_b  = 1'b1;
               data_b = mem_q[idx].data;
            end
         end
      end
   end

   assign bus.in_ready         = in_ready;
   assign bus.ctrl_writeEnable = deq;
   assign bus.ctrl_writeReg    = (count_q != '0) ? mem_q[head_q].rd   : 5'd0;
   assign bus.data_writeReg    = (count_q != '0) ? mem_q[head_q].data : 32'd0;
   assign bus.fwdA_hit         = hit_a;
   assign bus.fwdB_hit         = hit_b;
   assign bus.fwdA_data        = data_a;
   assign bus.fwdB_data        = data_b;
   assign bus.count            = count_q;

   always_ff @(posedge clock) begin
      // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
      if (ctrl_reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: entry storage has no reset; slots outside head..count are never read.
   always_ff @(posedge clock) begin
      if (enq) mem_q[tail_q] <= '{rd: bus.in_reg, data: bus.in_data};
   end
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios with literal
// expectations plus randomized traffic compared against a queue model.
module tb_wb_queue;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clock;
   logic ctrl_reset;
   bit   cmp_en;
   int   n_checks;
   int   n_pass;

   wb_queue_if #(.CW(CW)) bus ();

   wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ment_t;

   ment_t mq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a plain queue, oldest at index 0.
   always @(posedge clock) begin
      bit acc, drn;
      if (ctrl_reset) begin
         mq.delete();
      end else begin
         acc = bus.in_valid && (mq.size() < DEPTH) && (bus.in_reg != 5'd0);
         drn = (mq.size() != 0) && !bus.wb_stall;
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back('{rd: bus.in_reg, data: bus.in_data});
      end
   end

   function automatic void model_fwd(input logic [4:0] ra, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = 32'd0;
      if (ra != 5'd0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!hit && mq[i].rd == ra) begin
               hit = 1'b1;
               d   = mq[i].data;
            end
         end
      end
   endfunction

   always @(negedge clock) begin
      logic        eh;
      logic [31:0] ed;
      int          n;
      if (cmp_en) begin
         n = mq.size();
         check("count", 32'(bus.count), 32'(n));
         check("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
         check("write_en", 32'(bus.ctrl_writeEnable), 32'((n != 0) && !bus.wb_stall));
         check("write_reg", 32'(bus.ctrl_writeReg), (n != 0) ? 32'(mq[0].rd) : 32'd0);
         check("write_data", bus.data_writeReg, (n != 0) ? mq[0].data : 32'd0);
         model_fwd(bus.ctrl_readRegA, eh, ed);
         check("fwdA_hit", 32'(bus.fwdA_hit), 32'(eh));
         check("fwdA_data", bus.fwdA_data, ed);
         model_fwd(bus.ctrl_readRegB, eh, ed);
         check("fwdB_hit", 32'(bus.fwdB_hit), 32'(eh));
         check("fwdB_data", bus.fwdB_data, ed);
      end
   end

   task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic s, input logic [4:0] ra, input logic [4:0] rb);
      bus.in_valid      = v;
      bus.in_reg        = r;
      bus.in_data       = d;
      bus.wb_stall      = s;
      bus.ctrl_readRegA = ra;
      bus.ctrl_readRegB = rb;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      cmp_en     = 1'b0;
      ctrl_reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      ctrl_reset = 1'b0;
      cmp_en     = 1'b1;

      // Post-reset outputs.
      drive(0, 0, 0, 0, 5, 7);
      check("rst_count", 32'(bus.count), 0);
      check("rst_in_ready", 32'(bus.in_ready), 1);
      check("rst_we", 32'(bus.ctrl_writeEnable), 0);
      check("rst_wreg", 32'(bus.ctrl_writeReg), 0);
      check("rst_wdata", bus.data_writeReg, 0);
      check("rst_fwdA", 32'(bus.fwdA_hit), 0);
      check("rst_fwdB", 32'(bus.fwdB_hit), 0);
      check("rst_fwdA_data", bus.fwdA_data, 0);

      // Single write, one-cycle latency.
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("single_we", 32'(bus.ctrl_writeEnable), 1);
      check("single_wreg", 32'(bus.ctrl_writeReg), 5);
      check("single_wdata", bus.data_writeReg, 32'hDEADBEEF);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("single_drained", 32'(bus.count), 0);

      // Fill while stalled, fifth offer refused, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         drive(1, 5'(i), 32'h100 + 32'(i), 1, 0, 0);
         tick();
      end
      drive(1, 9, 32'h999, 1, 0, 0);
      check("full_count", 32'(bus.count), 4);
      check("full_ready", 32'(bus.in_ready), 0);
      check("full_we", 32'(bus.ctrl_writeEnable), 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("full_reject", 32'(bus.count), 4);
      for (int i = 1; i <= 4; i++) begin
         check("drain_we", 32'(bus.ctrl_writeEnable), 1);
         check("drain_wreg", 32'(bus.ctrl_writeReg), 32'(i));
         check("drain_wdata", bus.data_writeReg, 32'h100 + 32'(i));
         tick();
         drive(0, 0, 0, 0, 0, 0);
      end
      check("drain_empty", 32'(bus.count), 0);

      // Youngest match wins; read of r0 never hits.
      drive(1, 7, 32'h11, 1, 0, 0);
      tick();
      drive(1, 7, 32'h22, 1, 0, 0);
      tick();
      drive(1, 3, 32'h33, 1, 7, 0);
      check("fwd_young_hit", 32'(bus.fwdA_hit), 1);
      check("fwd_young_data", bus.fwdA_data, 32'h22);
      check("fwd_r0_hit", 32'(bus.fwdB_hit), 0);
      drive(0, 0, 0, 1, 3, 7);
      check("fwd_no_same_cycle", 32'(bus.fwdA_hit), 0);
      check("fwd_b_young", bus.fwdB_data, 32'h22);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("fwd_drained", 32'(bus.count), 0);

      // Register 0 is swallowed.
      drive(1, 0, 32'hFFFF, 0, 0, 0);
      check("r0_ready", 32'(bus.in_ready), 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("r0_count", 32'(bus.count), 0);
      check("r0_we", 32'(bus.ctrl_writeEnable), 0);
      check("r0_ready_after", 32'(bus.in_ready), 1);

      // Streaming at count 2 with simultaneous enqueue and dequeue, across wrap.
      drive(1, 10, 32'hA0, 1, 0, 0);
      tick();
      drive(1, 11, 32'hA1, 1, 0, 0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'(12 + i), 32'hB0 + 32'(i), 0, 0, 0);
         check("stream_count", 32'(bus.count), 2);
         check("stream_wreg", 32'(bus.ctrl_writeReg), (i < 2) ? 32'(10 + i) : 32'(10 + i));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      check("stream_count_end", 32'(bus.count), 2);
      check("stream_tail_order", 32'(bus.ctrl_writeReg), 20);
      tick();
      tick();
      drive(0, 0, 0, 0, 0, 0);

      // Reset with three pending and a simultaneous offer.
      for (int i = 1; i <= 3; i++) begin
         drive(1, 5'(i), 32'h300 + 32'(i), 1, 0, 0);
         tick();
      end
      ctrl_reset = 1'b1;
      drive(1, 4, 32'h304, 0, 1, 2);
      tick();
      ctrl_reset = 1'b0;
      drive(0, 0, 0, 0, 1, 2);
      check("rst_mid_count", 32'(bus.count), 0);
      check("rst_mid_we", 32'(bus.ctrl_writeEnable), 0);
      check("rst_mid_fwdA", 32'(bus.fwdA_hit), 0);
      check("rst_mid_fwdB", 32'(bus.fwdB_hit), 0);
      tick();

      // Randomized traffic; stall density changes per block to reach full and empty.
      for (int blk = 0; blk < 30; blk++) begin
         int stall_pct;
         stall_pct = $urandom_range(0, 90);
         for (int c = 0; c < 100; c++) begin
            ctrl_reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < stall_pct,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
         end
      end
      ctrl_reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending write entries (power of two, 2..16).
REQ-002 The block SHALL have parameter CW, default 3, meaning the count width, equal to log2(DEPTH)+1.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 ctrl_reset  input  1  reset; synchronous and active-high, sampled on the clock rising edge.
REQ-005 in_valid  input  1  producer offers a register write.
REQ-006 in_reg  input  5  destination register number.
REQ-007 in_data  input  32  write data.
REQ-008 in_ready  output  1  queue can accept an entry this cycle.
REQ-009 wb_stall  input  1  register-file write port unavailable; hold the head entry.
REQ-010 ctrl_writeEnable  output  1  register-file write strobe.
REQ-011 ctrl_writeReg  output  5  register-file write address.
REQ-012 data_writeReg  output  32  register-file write data.
REQ-013 ctrl_readRegA, ctrl_readRegB  input  5 each  register-file read addresses being issued this cycle.
REQ-014 fwdA_hit, fwdB_hit  output  1 each  a pending write matches the read address.
REQ-015 fwdA_data, fwdB_data  output  32 each  data of the youngest matching pending entry.
REQ-016 count  output  CW  number of pending entries.

Function
REQ-017 The block SHALL be a circular FIFO of DEPTH entries {reg[4:0], data[31:0]} with head and tail pointers and an occupancy counter.
REQ-018 An enqueue SHALL occur when in_valid && in_ready && in_reg != 0.
REQ-019 in_valid with in_reg == 0 and in_ready high SHALL be accepted and discarded, leaving the FIFO unchanged.
REQ-020 in_ready SHALL be (count < DEPTH), with no combinational dependence on the dequeue of the same cycle.
REQ-021 ctrl_writeEnable SHALL be (count != 0) && !wb_stall, with ctrl_writeReg and data_writeReg driven combinationally from the head entry.
REQ-022 When the FIFO is empty, ctrl_writeReg SHALL be 0 and data_writeReg SHALL be 0.
REQ-023 A dequeue SHALL occur on every edge where ctrl_writeEnable is high, advancing head by one.
REQ-024 Minimum latency SHALL be one cycle: an entry accepted at edge N drives ctrl_writeEnable in cycle N+1 if it is the head and wb_stall is low.
REQ-025 When an enqueue and a dequeue occur on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-027 Forwarding SHALL search all valid entries, including the head being written this cycle, for reg == ctrl_readRegX.
REQ-028 fwdX_hit SHALL be 1 on any match; fwdX_data SHALL be the data of the youngest (closest to tail) match.
REQ-029 The entry being enqueued in the same cycle SHALL NOT be forwarded.
REQ-030 ctrl_readRegX == 0 SHALL always give fwdX_hit = 0.
REQ-031 When there is no match, fwdX_data SHALL be 0.
REQ-032 Duplicate destinations SHALL all be written to the register file in order; no coalescing.

Reset
REQ-033 With ctrl_reset high at an edge, head, tail and count SHALL be cleared to 0 and all pending entries discarded, including any mid-drain or simultaneous enqueue.
REQ-034 After reset, outputs SHALL be: in_ready = 1, ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, fwdA_hit = 0, fwdB_hit = 0, fwdA_data = 0, fwdB_data = 0, count = 0.
REQ-035 Entry storage SHALL need no reset, because invalid entries are never observed.

Verification
REQ-036 Single write: enqueue (r5, 0xDEADBEEF) -> next cycle ctrl_writeEnable = 1, ctrl_writeReg = 5, data = 0xDEADBEEF; cycle after that count = 0.
REQ-037 Fill with wb_stall = 1: four enqueues r1..r4 -> count = 4, in_ready = 0; a fifth in_valid is not accepted; release the stall -> writes r1, r2, r3, r4 on four consecutive cycles.
REQ-038 Forwarding youngest: queue (r7, 0x11) then (r7, 0x22) while stalled, readRegA = 7 -> fwdA_hit = 1, fwdA_data = 0x22; readRegB = 0 -> fwdB_hit = 0.
REQ-039 Register 0: enqueue (r0, 0xFFFF) -> count stays 0, no write strobe, in_ready stays 1.
REQ-040 Simultaneous enqueue and dequeue at count = 2 -> count stays 2; run 10 streaming writes through to exercise pointer wrap, and order is preserved.
REQ-041 Reset mid-operation: ctrl_reset = 1 with count = 3 and in_valid = 1 -> next cycle count = 0, ctrl_writeEnable = 0, fwd hits 0.
